// File: rtl/texture_quad_buffer.sv
// Texel-quad texture memory: four replicated read ports (2-cycle latency) fed by an AXI-Stream loader.
// Define TEXTURE_DOUBLE_BUFFER_EN for front/back banks swapped on swapReq between packets.
module texture_quad_buffer #(
    parameter int unsigned CMD_STREAM_WIDTH = 64,
    parameter int unsigned PIXEL_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH       = 17
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata,
    input  logic [ADDR_WIDTH-1:0]       confLoadAddr,
    output logic                        loadDone,
    input  logic [ADDR_WIDTH-1:0]       texelAddr00,
    input  logic [ADDR_WIDTH-1:0]       texelAddr01,
    input  logic [ADDR_WIDTH-1:0]       texelAddr10,
    input  logic [ADDR_WIDTH-1:0]       texelAddr11,
    output logic [PIXEL_WIDTH-1:0]      texelOutput00,
    output logic [PIXEL_WIDTH-1:0]      texelOutput01,
    output logic [PIXEL_WIDTH-1:0]      texelOutput10,
    output logic [PIXEL_WIDTH-1:0]      texelOutput11,
    input  logic                        swapReq
);
    localparam int unsigned TexelsPerBeat = CMD_STREAM_WIDTH / PIXEL_WIDTH;
    localparam int unsigned CntWidth      = (TexelsPerBeat > 1) ? $clog2(TexelsPerBeat) : 1;
`ifdef TEXTURE_DOUBLE_BUFFER_EN
    localparam int unsigned RamAw = ADDR_WIDTH + 1;
`else
    localparam int unsigned RamAw = ADDR_WIDTH;
`endif
    localparam int unsigned RamDepth = 2 ** RamAw;

    typedef enum logic [1:0] {StIdle, StLoad, StUnpack, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q;
    logic [CntWidth-1:0]     cnt_q;
    logic                    last_q;
    logic [PIXEL_WIDTH-1:0]  beat_q [TexelsPerBeat];
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   load_base;
    logic [ADDR_WIDTH-1:0]   wr_texel_addr;
    logic [RamAw-1:0]        wr_addr;
    logic [PIXEL_WIDTH-1:0]  wr_data;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   texel_addr [4];

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign load_base = (state_q == StIdle) ? confLoadAddr : wr_ptr_q;

    // State register
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StLoad: begin
                if (accept) begin
                    if (TexelsPerBeat > 1) begin
                        state_d = StUnpack;
                    end else begin
                        state_d = s_axis_tlast ? StDone : StLoad;
                    end
                end
            end
            StUnpack: begin
                if (cnt_q == CntWidth'(TexelsPerBeat - 1)) begin
                    state_d = last_q ? StDone : StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; tready is forced low for as long as reset is held
    always_comb begin
        s_axis_tready = 1'b0;
        loadDone      = 1'b0;
        case (state_q)
            StIdle, StLoad: s_axis_tready = ~reset;
            StDone:         loadDone      = 1'b1;
            default:        ;
        endcase
    end

    // Texel 0 is written in the accept cycle, the rest from the held beat copy.
    always_comb begin
        wr_en         = accept | (state_q == StUnpack);
        wr_texel_addr = accept ? load_base : wr_ptr_q;
        wr_data       = accept ? s_axis_tdata[PIXEL_WIDTH-1:0] : beat_q[cnt_q];
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
        end else if (accept) begin
            wr_ptr_q <= load_base + ADDR_WIDTH'(1);
            cnt_q    <= CntWidth'(1);
            last_q   <= s_axis_tlast;
        end else if (state_q == StUnpack) begin
            wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            cnt_q    <= cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (accept) begin
            for (int k = 0; k < TexelsPerBeat; k++) begin
                beat_q[k] <= s_axis_tdata[k*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

`ifdef TEXTURE_DOUBLE_BUFFER_EN
    logic front_q, swap_pend_q, swap_want, swap_now;

    assign swap_want = swap_pend_q | swapReq;
    // A beat accepted in IDLE already targets the current back bank, so defer the swap.
    assign swap_now  = swap_want & (((state_q == StIdle) & ~accept) | (state_q == StDone));

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            front_q     <= front_q ^ swap_now;
            swap_pend_q <= swap_want & ~swap_now;
        end
    end

    assign wr_addr = {~front_q, wr_texel_addr};
`else
    logic unused_swap_req;
    assign unused_swap_req = swapReq;
    assign wr_addr         = wr_texel_addr;
`endif

    assign texel_addr[0] = texelAddr00;
    assign texel_addr[1] = texelAddr01;
    assign texel_addr[2] = texelAddr10;
    assign texel_addr[3] = texelAddr11;

    for (genvar q = 0; q < 4; q++) begin : g_quad
        logic [PIXEL_WIDTH-1:0] mem [RamDepth];
        logic [RamAw-1:0]       rd_addr_d, rd_addr_q;
        logic [PIXEL_WIDTH-1:0] rd_data_q;

`ifdef TEXTURE_DOUBLE_BUFFER_EN
        assign rd_addr_d = {front_q, texel_addr[q]};
`else
        assign rd_addr_d = texel_addr[q];
`endif

        always_ff @(posedge aclk) begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
        end

        // Read-first: a same-edge write to rd_addr_q is not visible until the next read.
        always_ff @(posedge aclk or posedge reset) begin
            if (reset) begin
                rd_addr_q <= '0;
                rd_data_q <= '0;
            end else begin
                rd_addr_q <= rd_addr_d;
                rd_data_q <= mem[rd_addr_q];
            end
        end
    end

    assign texelOutput00 = g_quad[0].rd_data_q;
    assign texelOutput01 = g_quad[1].rd_data_q;
    assign texelOutput10 = g_quad[2].rd_data_q;
    assign texelOutput11 = g_quad[3].rd_data_q;

endmodule
